// File: rtl/ram_pkg.sv
// Shared types and constants for the ram_two_pipe block.
package ram_pkg;

    // Controller state: zeroing sweep after reset, then normal operation.
    typedef enum logic {
        RAM_INIT = 1'b0,
        RAM_RUN  = 1'b1
    } ram_state_e;

    // Legal range of the read latency parameter.
    localparam int RAM_LAT_MIN = 1;
    localparam int RAM_LAT_MAX = 2;

    function automatic bit ram_lat_legal(input int lat);
        return (lat >= RAM_LAT_MIN) && (lat <= RAM_LAT_MAX);
    endfunction

endpackage

// File: rtl/ram_two_pipe_if.sv
// Bus bundle for ram_two_pipe: one write port, one read port, status.
interface ram_two_pipe_if #(
    parameter int Width = 32,
    parameter int Depth = 256
);
    localparam int Aw = $clog2(Depth);
    localparam int Nb = Width / 8;

    logic             we;
    logic [Aw-1:0]    waddr;
    logic [Width-1:0] wdata;
    logic [Nb-1:0]    wstrb;
    logic             re;
    logic [Aw-1:0]    raddr;
    logic [Width-1:0] rdata;
    logic             rvalid;
    logic             ready;

    modport master (
        output we, waddr, wdata, wstrb, re, raddr,
        input  rdata, rvalid, ready
    );

    modport slave (
        input  we, waddr, wdata, wstrb, re, raddr,
        output rdata, rvalid, ready
    );
endinterface

// File: rtl/ram_rd_pipe.sv
// Read return pipeline: Latency stages of valid + data. Data stages load
// only alongside a valid bit, so the output word holds between reads.
module ram_rd_pipe #(
    parameter int Width   = 32,
    parameter int Latency = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             vld_i,
    input  logic [Width-1:0] data_i,
    output logic             vld_o,
    output logic [Width-1:0] data_o
);

    logic [Latency-1:0]            vld_q;
    logic [Latency-1:0][Width-1:0] dat_q;
    logic [Latency:0]              vld_pipe;
    logic [Latency:0][Width-1:0]   dat_pipe;

    // Stage 0 is the combinational input; stage s+1 is register s.
    assign vld_pipe = {vld_q, vld_i};
    assign dat_pipe = {dat_q, data_i};

    // Shift valids every cycle; move data only with a valid so it holds.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            for (int s = 0; s < Latency; s++) begin
                vld_q[s] <= vld_pipe[s];
                if (vld_pipe[s]) dat_q[s] <= dat_pipe[s];
            end
        end
    end

    assign vld_o  = vld_pipe[Latency];
    assign data_o = dat_pipe[Latency];

endmodule

// File: rtl/ram_two_pipe.sv
// Byte-strobed 1W/1R RAM with a self-zeroing sweep after reset and a
// fixed-latency read return pipeline.
// Build option: define RAM_BYPASS_EN to forward same-cycle write bytes into
// a same-address read; otherwise such a read returns the pre-write word.
module ram_two_pipe
    import ram_pkg::*;
#(
    parameter  int Width   = 32,
    parameter  int Depth   = 256,
    parameter  int Latency = 1,
    localparam int Aw      = $clog2(Depth),
    localparam int Nb      = Width / 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [Aw-1:0]    waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [Nb-1:0]    wstrb_i,
    input  logic             re_i,
    input  logic [Aw-1:0]    raddr_i,
    output logic [Width-1:0] rdata_o,
    output logic             rvalid_o,
    output logic             ready_o
);

    if (((Width % 8) != 0) || !ram_lat_legal(Latency)) begin : g_bad_cfg
        $error("ram_two_pipe: Width must be a multiple of 8 and Latency 1 or 2");
    end

    localparam logic [Aw:0]   DepthW = (Aw + 1)'(Depth);
    localparam logic [Aw-1:0] LastA  = Aw'(Depth - 1);

    ram_state_e       state_q, state_d;
    logic [Aw-1:0]    init_addr_q, init_addr_d;
    logic             init_we;
    logic             waddr_ok, raddr_ok;
    logic             wr_fire, rd_fire;
    logic [Width-1:0] rd_word;
    logic [Width-1:0] mem_q [Depth];

    assign ready_o  = (state_q == RAM_RUN);
    // Address width can exceed Depth, so out-of-range accesses are filtered.
    assign waddr_ok = ({1'b0, waddr_i} < DepthW);
    assign raddr_ok = ({1'b0, raddr_i} < DepthW);
    assign wr_fire  = ready_o && we_i && waddr_ok;
    assign rd_fire  = ready_o && re_i;

    // State and sweep-address registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RAM_INIT;
            init_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
        end
    end

    // INIT zeroes one word per cycle, leaving after the last address.
    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        init_we     = 1'b0;
        case (state_q)
            RAM_INIT: begin
                init_we     = 1'b1;
                init_addr_d = init_addr_q + 1'b1;
                if (init_addr_q == LastA) state_d = RAM_RUN;
            end
            RAM_RUN: ;
            default: state_d = RAM_INIT;
        endcase
    end

    // Storage: no reset; the INIT sweep is the only zeroing mechanism.
    always_ff @(posedge clk_i) begin
        if (init_we) begin
            mem_q[init_addr_q] <= '0;
        end else if (wr_fire) begin
            for (int b = 0; b < Nb; b++) begin
                if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    // Read word for this cycle; out-of-range reads return zero.
    always_comb begin
        rd_word = '0;
        if (raddr_ok) rd_word = mem_q[raddr_i];
`ifdef RAM_BYPASS_EN
        if (wr_fire && (waddr_i == raddr_i)) begin
            for (int b = 0; b < Nb; b++) begin
                if (wstrb_i[b]) rd_word[b*8 +: 8] = wdata_i[b*8 +: 8];
            end
        end
`endif
    end

    ram_rd_pipe #(
        .Width   (Width),
        .Latency (Latency)
    ) u_rd_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .vld_i  (rd_fire),
        .data_i (rd_word),
        .vld_o  (rvalid_o),
        .data_o (rdata_o)
    );

endmodule

// File: tb/tb_ram_two_pipe.sv
// Bench for ram_two_pipe (Depth=200, Latency=2): directed vectors, a
// cycle-count/array reference model and a per-cycle output compare.
module tb_ram_two_pipe;

    localparam int W   = 32;
    localparam int D   = 200;
    localparam int LAT = 2;
    localparam int AW  = $clog2(D);
    localparam int NB  = W / 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ram_two_pipe_if #(.Width(W), .Depth(D)) bus ();

    ram_two_pipe #(.Width(W), .Depth(D), .Latency(LAT)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .we_i     (bus.we),
        .waddr_i  (bus.waddr),
        .wdata_i  (bus.wdata),
        .wstrb_i  (bus.wstrb),
        .re_i     (bus.re),
        .raddr_i  (bus.raddr),
        .rdata_o  (bus.rdata),
        .rvalid_o (bus.rvalid),
        .ready_o  (bus.ready)
    );

    int vecs = 0;
    int errs = 0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int           due;
        logic [W-1:0] data;
    } rd_t;

    rd_t          q[$];
    logic [W-1:0] mm [D];
    int           n = 0;          // clock edges since reset release
    logic [W-1:0] exp_last = '0;
    logic [W-1:0] rv_log[$];

    // Ready after D edges; reads/writes honoured only once ready.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            n = 0;
            q.delete();
            for (int i = 0; i < D; i++) mm[i] = '0;
        end else if (clk) begin
            if (n >= D) begin
                if (bus.re) begin
                    rd_t r;
                    r.data = (int'(bus.raddr) < D) ? mm[bus.raddr] : '0;
`ifdef RAM_BYPASS_EN
                    if (bus.we && bus.waddr == bus.raddr && int'(bus.raddr) < D)
                        for (int b = 0; b < NB; b++)
                            if (bus.wstrb[b]) r.data[b*8 +: 8] = bus.wdata[b*8 +: 8];
`endif
                    r.due = n + LAT;
                    q.push_back(r);
                end
                if (bus.we && int'(bus.waddr) < D)
                    for (int b = 0; b < NB; b++)
                        if (bus.wstrb[b]) mm[bus.waddr][b*8 +: 8] = bus.wdata[b*8 +: 8];
            end
            n++;
        end
    end

    // Compare every cycle on the falling edge.
    initial forever begin
        logic exp_v;
        rd_t  r;
        @(negedge clk);
        if (!rst_n) exp_last = '0;
        exp_v = 1'b0;
        if (q.size() > 0 && q[0].due < n) begin
            r = q.pop_front();
            check("missed_read", 32'(r.due), 32'(n));
        end
        if (q.size() > 0 && q[0].due == n) begin
            exp_v    = 1'b1;
            r        = q.pop_front();
            exp_last = r.data;
        end
        check("rvalid", W'(bus.rvalid), W'(exp_v));
        check("rdata", bus.rdata, exp_last);
        check("ready", W'(bus.ready), W'(n >= D));
        if (bus.rvalid) rv_log.push_back(bus.rdata);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.we = 1'b0; bus.re = 1'b0;
        bus.wstrb = '0; bus.wdata = '0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [NB-1:0] s);
        bus.we = 1'b1; bus.waddr = a; bus.wdata = d; bus.wstrb = s;
        step();
        bus.we = 1'b0;
    endtask

    task automatic lit_read(input string name, input logic [AW-1:0] a, input logic [W-1:0] exp);
        bus.re = 1'b1; bus.raddr = a;
        step();
        bus.re = 1'b0;
        repeat (LAT - 1) step();
        @(negedge clk);
        check({name, "_vld"}, W'(bus.rvalid), 1);
        check(name, bus.rdata, exp);
    endtask

    task automatic wait_ready(input int stim, output int cnt);
        cnt = 0;
        while (!bus.ready && cnt < D + 20) begin
            if (stim != 0) begin
                bus.we = 1'b1; bus.waddr = AW'(cnt % D); bus.wdata = '1; bus.wstrb = '1;
                bus.re = 1'b1; bus.raddr = AW'(cnt % D);
            end
            step();
            cnt++;
        end
        idle();
    endtask

    logic [W-1:0] svals [4] = '{32'h0101_A0A0, 32'h0202_B0B0, 32'h0303_C0C0, 32'h0404_D0D0};

    initial begin
        int cnt;
        idle();
        bus.waddr = '0; bus.raddr = '0;
        #1 rst_n = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("rst_ready", W'(bus.ready), 0);
        check("rst_rvalid", W'(bus.rvalid), 0);
        check("rst_rdata", bus.rdata, 0);
        step();
        rst_n = 1'b1;

        // INIT length, with traffic that must be ignored
        wait_ready(1, cnt);
        check("init_len", W'(cnt), W'(D));

        // every address reads zero after INIT
        bus.re = 1'b1;
        for (int a = 0; a < D; a++) begin
            bus.raddr = AW'(a);
            step();
        end
        bus.re = 1'b0;
        repeat (LAT + 1) step();
        lit_read("init_zero", 8'h10, 32'h0);

        // strobed write merge
        wr(8'h10, 32'hAABBCCDD, 4'hF);
        wr(8'h10, 32'h11223344, 4'b0101);
        lit_read("strobe", 8'h10, 32'hAA22CC44);

        // streaming reads
        for (int i = 0; i < 4; i++) wr(AW'(i + 1), svals[i], 4'hF);
        step();
        rv_log.delete();
        bus.re = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.raddr = AW'(i + 1);
            step();
        end
        bus.re = 1'b0;
        repeat (LAT + 2) step();
        check("stream_cnt", W'(rv_log.size()), 4);
        for (int i = 0; i < 4 && i < rv_log.size(); i++) check("stream_data", rv_log[i], svals[i]);

        // same-address collision
        bus.we = 1'b1; bus.waddr = 8'd5; bus.wdata = 32'hFFFFFFFF; bus.wstrb = 4'b0011;
        bus.re = 1'b1; bus.raddr = 8'd5;
        step();
        idle();
        repeat (LAT - 1) step();
        @(negedge clk);
        check("coll_vld", W'(bus.rvalid), 1);
`ifdef RAM_BYPASS_EN
        check("coll_data", bus.rdata, 32'h0000FFFF);
`else
        check("coll_data", bus.rdata, 32'h00000000);
`endif
        lit_read("coll_after", 8'd5, 32'h0000FFFF);

        // independent read and write in one cycle
        bus.we = 1'b1; bus.waddr = 8'd6; bus.wdata = 32'h66666666; bus.wstrb = 4'hF;
        bus.re = 1'b1; bus.raddr = 8'd1;
        step();
        idle();
        repeat (LAT - 1) step();
        @(negedge clk);
        check("rw_diff", bus.rdata, 32'h0101_A0A0);
        lit_read("rw_diff_wr", 8'd6, 32'h66666666);
        step(); step();
        @(negedge clk);
        check("hold_vld", W'(bus.rvalid), 0);
        check("hold_data", bus.rdata, 32'h66666666);

        // out-of-range access
        wr(8'd220, 32'hDEADBEEF, 4'hF);
        lit_read("oor_read", 8'd220, 32'h0);
        lit_read("oor_alias", 8'd20, 32'h0);

        // reset with a read in flight
        step();
        bus.re = 1'b1; bus.raddr = 8'h10;
        step();
        bus.re = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_vld", W'(bus.rvalid), 0);
        check("mid_rst_data", bus.rdata, 0);
        check("mid_rst_ready", W'(bus.ready), 0);
        step(); step();
        rst_n = 1'b1;
        wait_ready(0, cnt);
        check("reinit_len", W'(cnt), W'(D));
        lit_read("reinit_zero", 8'h10, 32'h0);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
